// File: rtl/if_stage_ibuf_pkg.sv
// Shared definitions for the buffered fetch stage: decode bus layout and reset vector.
package if_stage_ibuf_pkg;

  localparam int FS_TO_DS_BUS_WD = 65;
  localparam int BUS_ADEL_BIT    = 64;
  localparam int BUS_INST_LSB    = 32;
  localparam int BUS_PC_LSB      = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;

  // Field order matches the bus: {adel, inst, pc}.
  typedef struct packed {
    logic        adel;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_entry_t;

endpackage

// File: rtl/if_stage_ibuf_fifo.sv
// Synchronous FIFO with occupancy count and flush; head is read straight from storage (no bypass).
module sync_fifo_cnt #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // A flush discards both the contents and any same-cycle push/pop.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(do_push && !do_pop && count_reg == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(do_pop && count_reg == '0));

endmodule

// File: rtl/if_stage_ibuf.sv
// Fetch stage: PC generation, pipelined inst SRAM requests and a DEPTH-entry instruction buffer.
module if_stage_ibuf
  import if_stage_ibuf_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       flush_valid,
  input  logic [31:0]                flush_pc,
  input  logic                       wr_re,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       inst_sram_addrok,
  input  logic                       inst_sram_dataok
);

  localparam int BCW = $clog2(DEPTH + 1);
  localparam int QCW = $clog2(MAX_OUTST + 1);
  localparam int DCW = $clog2(MAX_OUTST + 2);

  logic [31:0]    fetch_pc_reg;
  logic           fetch_halt_reg;
  logic           pend_reg;
  logic [31:0]    pend_addr_reg;
  logic           pend_stale_reg;
  logic [DCW-1:0] discard_reg;

  logic [BCW-1:0] ibuf_count;
  logic [QCW-1:0] inflight;
  logic [QCW-1:0] inflight_next;
  logic [BCW:0]   occupancy;
  fs_entry_t      ibuf_head;
  fs_entry_t      ibuf_wdata;
  logic [31:0]    pcq_head;
  logic           want, hs, pend_next, drop, ret_push, adel_push, ibuf_push, ibuf_pop;

  // The PC FIFO count doubles as the in-flight counter.
  assign occupancy = {1'b0, ibuf_count} + (BCW + 1)'(inflight);
  assign want = ~fetch_halt_reg & (inflight < QCW'(MAX_OUTST))
              & (occupancy < (BCW + 1)'(DEPTH)) & (fetch_pc_reg[1:0] == 2'b00);

  // A request already on the bus stays there regardless of wr_re or flush.
  assign inst_sram_req   = ~reset & (pend_reg | (want & ~wr_re));
  assign inst_sram_addr  = pend_reg ? pend_addr_reg : fetch_pc_reg;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wdata = 32'h0;

  assign hs            = inst_sram_req & inst_sram_addrok;
  assign pend_next     = inst_sram_req & ~inst_sram_addrok;
  assign inflight_next = inflight + QCW'(hs) - QCW'(inst_sram_dataok);

  assign drop      = inst_sram_dataok & (discard_reg != '0);
  assign ret_push  = inst_sram_dataok & ~drop;
  assign adel_push = ~fetch_halt_reg & (fetch_pc_reg[1:0] != 2'b00) & (inflight == '0)
                   & (discard_reg == '0) & ~pend_reg & (ibuf_count < BCW'(DEPTH));
  assign ibuf_push = ret_push | adel_push;

  always_comb begin
    ibuf_wdata = '{adel: 1'b0, inst: inst_sram_rdata, pc: pcq_head};
    if (!ret_push) ibuf_wdata = '{adel: 1'b1, inst: 32'h0, pc: fetch_pc_reg};
  end

  assign fs_to_ds_valid = (ibuf_count != '0) & ~flush_valid;
  assign fs_to_ds_bus   = fs_to_ds_valid ? ibuf_head : '0;
  assign ibuf_pop       = fs_to_ds_valid & ds_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg   <= RESET_PC;
      fetch_halt_reg <= 1'b0;
      pend_reg       <= 1'b0;
      pend_addr_reg  <= 32'h0;
      pend_stale_reg <= 1'b0;
      discard_reg    <= '0;
    end else begin
      pend_reg       <= pend_next;
      pend_addr_reg  <= inst_sram_addr;
      // A pending request that survives a flush belongs to the old path.
      pend_stale_reg <= pend_next & (flush_valid | pend_stale_reg);
      if (flush_valid) begin
        fetch_pc_reg   <= flush_pc;
        fetch_halt_reg <= 1'b0;
        discard_reg    <= DCW'(inflight_next) + DCW'(pend_next);
      end else begin
        if (hs && !(pend_reg && pend_stale_reg)) fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (drop)      discard_reg    <= discard_reg - DCW'(1);
        if (adel_push) fetch_halt_reg <= 1'b1;
      end
    end
  end

  sync_fifo_cnt #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(DEPTH)) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .push      (ibuf_push),
    .push_data (ibuf_wdata),
    .pop       (ibuf_pop),
    .flush     (flush_valid),
    .head      (ibuf_head),
    .count     (ibuf_count)
  );

  // Discarded requests still pop their PC here when their data returns.
  sync_fifo_cnt #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_pcq (
    .clk       (clk),
    .reset     (reset),
    .push      (hs),
    .push_data (inst_sram_addr),
    .pop       (inst_sram_dataok),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (inflight)
  );

endmodule

// File: doc/if_stage_ibuf.md
Name: if_stage_ibuf

Overview:
- Parametrised successor to the single-entry fetch stage.
- Generates the PC and issues requests on the inst SRAM-like interface, with up to MAX_OUTST requests in flight.
- Returned instructions go into a DEPTH-entry instruction buffer that drains to the decode stage via valid/allowin.
- A single flush/redirect port cancels in-flight fetches and buffered instructions. Exception, ERET and branch priority and delay-slot timing are resolved upstream and merged onto this port.

Parameters:
- DEPTH, 4, instruction-buffer entries (power of 2, ≥2).
- MAX_OUTST, 2, maximum accepted-but-not-returned requests (power of 2, ≥1, ≤DEPTH).
- RESET_PC, 32'hbfc00000, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  decode can accept this cycle
- fs_to_ds_valid  out  1  buffer head valid
- fs_to_ds_bus  out  FS_TO_DS_BUS_WD(65)  {adel[64], inst[63:32], pc[31:0]}
- flush_valid  in  1  redirect fetch to flush_pc
- flush_pc  in  32  redirect target
- wr_re  in  1  data side owns the shared bus; suppress inst_sram_req
- inst_sram_req  out  1  request
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2
- inst_sram_addr  out  32  request address
- inst_sram_wdata  out  32  constant 0
- inst_sram_rdata  in  32  returned instruction
- inst_sram_addrok  in  1  request accepted this cycle
- inst_sram_dataok  in  1  data returned this cycle, in request order

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - req 0, fs_to_ds_valid 0, fs_to_ds_bus 0.
  - fetch_pc = RESET_PC; ibuf count, in-flight count and discard count all 0.
  - fetch_halt 0.
- Request issue:
  - inst_sram_req = want & ~wr_re.
  - want = ~fetch_halt & inflight<MAX_OUTST & (ibuf_count+inflight)<DEPTH & fetch_pc[1:0]==0.
  - inst_sram_addr = fetch_pc.
- Pending request: once req has been driven high without addrok, addr and req are held until addrok. This holds even across flush and even if wr_re rises; wr_re masks req only before the first assertion.
- Request acceptance: handshake = req & addrok.
  - Push fetch_pc into the PC FIFO (depth MAX_OUTST); inflight+1; fetch_pc += 4 (32-bit wrap).
- Data return: dataok pops the PC FIFO; inflight-1.
  - If discard>0: discard-1, data dropped.
  - Else: push {0, rdata, pc} into ibuf. Space is guaranteed by the issue rule; overflow is a design error, checked by assertion.
- Misaligned fetch_pc: no request is issued.
  - Once inflight==0 and discard==0, push {1, 32'b0, fetch_pc} into ibuf, then set fetch_halt.
  - fetch_halt clears only on flush.
- Drain: fs_to_ds_valid = ibuf_count!=0; bus = head entry; pop when valid & ds_allowin.
- flush_valid (highest priority, same cycle):
  - ibuf emptied and fs_to_ds_valid forced 0; the same-cycle pop is ignored.
  - discard = inflight after this cycle's accept/return, plus 1 if a request is pending unaccepted (it will be accepted later, then dropped).
  - fetch_pc = flush_pc; fetch_halt = 0.
  - The first new request issues no earlier than the cycle after flush, and only after any pending request is accepted.
- Simultaneous events:
  - accept+dataok in the same cycle: inflight unchanged.
  - push+pop in the same cycle: count unchanged.
  - flush during reset: reset wins.
- Latency: addr issued at cycle T. With dataok at T+1, the entry is visible to decode at T+2 (registered buffer).
- Throughput: 1 instr/cycle sustained when the SRAM returns 1 cycle after acceptance and MAX_OUTST≥2.

Decomposition:
- mycpu.h: FS_TO_DS_BUS_WD=65, bus field offsets, RESET_PC.
- One sub-module, sync_fifo_cnt (WIDTH, DEPTH): push/pop/flush, count output, no bypass. Instantiated twice: ibuf (width 65) and PC FIFO (width 32).

Test Plan:
- Reset release with zero-wait SRAM (addrok always 1, dataok 1 cycle later) -> addrs bfc00000, bfc00004, …; decode receives one instr per cycle after a 2-cycle fill.
- ds_allowin=0 held → req deasserts once ibuf_count+inflight==DEPTH (4); releasing allowin drains 4 entries in order with no loss or duplicates.
- 2 requests in flight, then flush_pc=bfc00380 → both returned datas dropped; next bus pc=bfc00380.
- req high, addrok low, then flush → addr held at old value until addrok; that response is discarded; next request goes to flush_pc.
- flush_pc=bfc00382 → single entry adel=1, pc=bfc00382, inst=0; no SRAM request; fetch halted until the next flush to bfc00000 resumes.
- wr_re=1 with an idle request → req=0; wr_re falling → req=1 with same addr; addrok in same cycle as dataok → inflight unchanged.
